// File: rtl/ddr2_patrol_scrubber.sv
// ddr2_patrol_scrubber: background patrol scrub with CE write-back, error logging and read timeout
module ddr2_patrol_scrubber #(
  parameter int ADDR_WIDTH  = 25,
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_LEN   = 8,
  parameter int IDLE_CYCLES = 100,
  parameter int RD_TIMEOUT  = 1024,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  one_shot,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  input  logic                  err_clr,
  input  logic                  ready,
  input  logic                  notfull,
  input  logic                  host_busy,
  output logic [2:0]            cmd,
  output logic [1:0]            sz,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  cmd_put,
  output logic                  data_put,
  output logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fetching,
  input  logic                  validout,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  ecc_single_err,
  input  logic                  ecc_double_err,
  output logic [ADDR_WIDTH-1:0] scrub_progress,
  output logic                  scrub_active,
  output logic                  pass_done,
  output logic [CNT_WIDTH-1:0]  ce_count,
  output logic [CNT_WIDTH-1:0]  ue_count,
  output logic                  ue_valid,
  output logic [ADDR_WIDTH-1:0] ue_addr,
  output logic                  rd_timeout
);
  localparam int LB = $clog2(BURST_LEN);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(RD_TIMEOUT - 1);
  localparam logic [1:0] SZ = 2'(LB - 3);
  localparam logic [2:0] BLR = 3'b011;
  localparam logic [2:0] BLW = 3'b100;
  typedef enum logic [2:0] {IDLE, WAIT_IDLE, ISSUE_READ, WAIT_DATA, ISSUE_WRITE, WRITE_DATA, NEXT} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] win_start, win_end, cur;
  logic [IW-1:0] idle_cnt;
  logic [TW-1:0] tmo;
  logic [LB-1:0] wcnt, widx;
  logic ce_f, ue_f;
  logic [DATA_WIDTH-1:0] buffer [BURST_LEN];
  logic [ADDR_WIDTH:0] nxt;
  logic pass_end, stop, go, hit, ce_w, ue_w;
  // Next burst base with carry-out, pass/stop decision, and per-word error classification
  always_comb begin
    nxt = {1'b0, cur} + (ADDR_WIDTH + 1)'(BURST_LEN);
    pass_end = nxt > {1'b0, win_end};
    stop = !enable || (pass_end && one_shot);
    go = notfull && ready;
    hit = validout && fetching;
    ue_w = hit && ecc_double_err;
    ce_w = hit && ecc_single_err && !ecc_double_err;
  end
  // Returned words land at their burst offset, so out-of-order return is tolerated
  always_ff @(posedge clk)
    if (state == WAIT_DATA && hit) buffer[raddr[LB-1:0]] <= data_out;
  // Scrub sequencer with registered command, data and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cmd <= '0;
      sz <= '0;
      addr <= '0;
      cmd_put <= 1'b0;
      data_put <= 1'b0;
      data_in <= '0;
      scrub_progress <= '0;
      scrub_active <= 1'b0;
      pass_done <= 1'b0;
      ce_count <= '0;
      ue_count <= '0;
      ue_valid <= 1'b0;
      ue_addr <= '0;
      rd_timeout <= 1'b0;
      win_start <= '0;
      win_end <= '0;
      cur <= '0;
      idle_cnt <= '0;
      tmo <= '0;
      wcnt <= '0;
      widx <= '0;
      ce_f <= 1'b0;
      ue_f <= 1'b0;
    end else begin
      cmd_put <= 1'b0;
      data_put <= 1'b0;
      pass_done <= 1'b0;
      rd_timeout <= 1'b0;
      case (state)
        IDLE: if (enable && ready) begin
          win_start <= start_addr;
          win_end <= end_addr;
          cur <= start_addr;
          scrub_progress <= start_addr;
          idle_cnt <= '0;
          state <= WAIT_IDLE;
        end
        WAIT_IDLE: begin
          idle_cnt <= (go && !host_busy) ? idle_cnt + 1'b1 : '0;
          if (!enable) begin
            state <= IDLE;
            scrub_active <= 1'b0;
          end else if (go && !host_busy && idle_cnt == IDLE_LAST) state <= ISSUE_READ;
        end
        ISSUE_READ: if (go) begin
          cmd_put <= 1'b1;
          cmd <= BLR;
          sz <= SZ;
          addr <= cur;
          scrub_active <= 1'b1;
          tmo <= '0;
          wcnt <= '0;
          ce_f <= 1'b0;
          ue_f <= 1'b0;
          state <= WAIT_DATA;
        end
        WAIT_DATA: begin
          tmo <= tmo + 1'b1;
          if (hit) wcnt <= wcnt + 1'b1;
          if (ue_w) begin
            ue_f <= 1'b1;
            ue_valid <= 1'b1;
            ue_addr <= raddr;
            if (~&ue_count) ue_count <= ue_count + 1'b1;
          end
          if (ce_w) begin
            ce_f <= 1'b1;
            if (~&ce_count) ce_count <= ce_count + 1'b1;
          end
          if (hit && &wcnt) state <= ((ce_f || ce_w) && !(ue_f || ue_w)) ? ISSUE_WRITE : NEXT;
          else if (tmo == TMO_LAST) begin
            rd_timeout <= 1'b1;
            state <= NEXT;
          end
        end
        ISSUE_WRITE: if (go) begin
          cmd_put <= 1'b1;
          cmd <= BLW;
          sz <= SZ;
          addr <= cur;
          widx <= '0;
          state <= WRITE_DATA;
        end
        WRITE_DATA: if (notfull) begin
          data_put <= 1'b1;
          data_in <= buffer[widx];
          widx <= widx + 1'b1;
          if (&widx) state <= NEXT;
        end
        NEXT: begin
          idle_cnt <= '0;
          pass_done <= pass_end;
          state <= stop ? IDLE : WAIT_IDLE;
          if (stop) scrub_active <= 1'b0;
          if (!(pass_end && stop)) begin
            cur <= pass_end ? win_start : nxt[ADDR_WIDTH-1:0];
            scrub_progress <= pass_end ? win_start : nxt[ADDR_WIDTH-1:0];
          end
        end
        default: state <= IDLE;
      endcase
      if (err_clr) begin
        ce_count <= '0;
        ue_count <= '0;
        ue_valid <= 1'b0;
        ue_addr <= '0;
      end
    end
  end
endmodule
